// File: rtl/imem_load_ctrl.sv
// Boot-load controller: packs a host byte stream into 32-bit words, writes them
// into instruction memory at sequential addresses, then releases the core reset.
module imem_load_ctrl #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        im_WE,
    output logic [31:0] im_addr,
    output logic [31:0] im_W_Ins,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      state_reg, state_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] word_idx_reg, word_idx_next;
    logic [15:0] len_reg, len_next;
    logic [31:0] asm_reg, asm_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wins_reg, wins_next;

    logic        accept;
    logic        len_ok;
    logic [15:0] word_inc;
    logic [31:0] asm_lanes;

    assign accept   = (state_reg == S_RECV) && in_valid;
    assign len_ok   = (len != 16'd0) && ({1'b0, len} <= DEPTH_L);
    assign word_inc = word_idx_reg + 16'd1;

    // Little-endian packing: the byte count selects which lane takes the byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_lanes[gi*8 +: 8] =
                (accept && (byte_cnt_reg == 2'(gi))) ? in_data : asm_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= S_IDLE;
            byte_cnt_reg <= 2'd0;
            word_idx_reg <= 16'd0;
            len_reg      <= 16'd0;
            asm_reg      <= 32'd0;
            addr_reg     <= 32'd0;
            wins_reg     <= 32'd0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            word_idx_reg <= word_idx_next;
            len_reg      <= len_next;
            asm_reg      <= asm_next;
            addr_reg     <= addr_next;
            wins_reg     <= wins_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        word_idx_next = word_idx_reg;
        len_next      = len_reg;
        asm_next      = asm_reg;
        addr_next     = addr_reg;
        wins_next     = wins_reg;

        case (state_reg)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    if (len_ok) begin
                        len_next      = len;
                        word_idx_next = 16'd0;
                        byte_cnt_next = 2'd0;
                        asm_next      = 32'd0;
                        state_next    = S_RECV;
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    asm_next      = asm_lanes;
                    if (byte_cnt_reg == 2'd3) begin
                        // Write port registers are loaded here so they hold after WRITE.
                        addr_next  = {14'd0, word_idx_reg, 2'b00};
                        wins_next  = asm_lanes;
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_next = word_inc;
                state_next    = (word_inc == len_reg) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        im_WE    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        case (state_reg)
            S_RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                im_WE = 1'b1;
                busy  = 1'b1;
            end
            S_DONE:  done    = 1'b1;
            S_RUN:   cpu_rst = 1'b0;
            S_ERR:   err     = 1'b1;
            default: ;
        endcase
    end

    assign im_addr  = addr_reg;
    assign im_W_Ins = wins_reg;

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-load controller for the instruction memory of the single-clock MIPS core. It accepts a byte stream from a host over a valid/ready handshake and packs it into 32-bit words. Each word is written into instruction memory through its `WE`/`W_Ins` write port at sequential word addresses. The fetch stage is held in reset until a load completes, then released so the PC starts from 0.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: instruction memory capacity in words; upper bound for `len`.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a load session; sampled only in IDLE, RUN, ERR.
- `len`  in  16  number of words to load; sampled together with `start`.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  controller accepts a byte this cycle.
- `im_WE`  out  1  instruction memory write enable.
- `im_addr`  out  32  instruction memory byte address, word-aligned.
- `im_W_Ins`  out  32  instruction word to write.
- `cpu_rst`  out  1  reset to the fetch stage/core (1 = held).
- `busy`  out  1  load session in progress (RECV or WRITE).
- `done`  out  1  one-cycle pulse on load completion.
- `err`  out  1  `len` rejected; held while in ERR.

## Operation
- **States:** IDLE, RECV, WRITE, DONE, RUN, ERR.
- **Reset:** state IDLE, byte count 0, word index 0, assembly register 0.
  - Output values: `cpu_rst`=1, `in_ready`=0, `im_WE`=0, `im_addr`=0, `im_W_Ins`=0, `busy`=0, `done`=0, `err`=0.
- **IDLE / RUN / ERR, `start`=1:**
  - If `len`==0 or `len`>`DEPTH_WORDS`, go to ERR.
  - Otherwise latch `len`, clear word index and byte count, and go to RECV.
- **RECV:** `in_ready`=1. A byte is accepted when `in_valid`&&`in_ready`.
  - Bytes are packed little-endian: 1st byte → [7:0], 2nd → [15:8], 3rd → [23:16], 4th → [31:24].
  - Byte count wraps 3→0. Acceptance of the 4th byte moves the state to WRITE.
  - `in_valid`=0 stalls indefinitely with no state change.
- **WRITE:** lasts exactly one cycle, with `in_ready`=0.
  - Outputs: `im_WE`=1, `im_W_Ins` = assembled word, `im_addr` = 4 × word index.
  - Word index then increments. If the new index equals latched `len`, go to DONE; else go to RECV.
- **DONE:** `done`=1 for one cycle, `cpu_rst` still 1; then go to RUN.
- **RUN:** `cpu_rst`=0 and the core executes from PC 0. `start` triggers a reload: `cpu_rst` returns to 1 on the next cycle.
- **ERR:** `err`=1 and `cpu_rst`=1. The state is left only by an acceptable `start` or by `RST`.
- **`cpu_rst`:** 0 only in RUN.
- **`busy`:** 1 in RECV and WRITE.
- **`start` while busy or in DONE:** ignored; `len` is not resampled.
- **Outside WRITE:** `im_WE`=0, `im_addr`/`im_W_Ins` hold their last written values.
- **Address width:** word index is 16 bits and is zero-extended then shifted left 2 to form `im_addr`. Maximum address is 4×(`DEPTH_WORDS`−1).

## Timing
- `start` accepted at edge t: RECV from cycle t+1, `in_ready`=1 in that cycle.
- 4th byte of a word accepted at edge c: `im_WE`=1 during cycle c+1, and the memory write happens at edge c+2.
- The next byte cannot be accepted before cycle c+2. Each word therefore costs at least 5 cycles.
- Last word written at edge c+2: DONE during cycle c+2 (`done`=1), RUN from cycle c+3 (`cpu_rst`=0).
- Minimum total from the `start` edge to `cpu_rst` falling is 5×`len`+2 cycles.
- `RST` mid-session:
  - All outputs take their reset values on the next cycle.
  - Partially assembled bytes are discarded.
  - Words already written stay in memory.
  - No `done` pulse is produced.
- `RST` and `start` in the same cycle: `RST` wins.

## Test plan
- **Two-word load:**
  - Stimulus: `start` with `len`=2, then bytes 13 00 00 00 93 00 10 00 (hex) back-to-back.
  - Response: `im_WE` pulses at addr 0 with data 0x00000013, then at addr 4 with data 0x00100093.
  - Then `done` pulses for one cycle, and `cpu_rst` falls exactly one cycle after `done`.
- **Backpressure:**
  - Stimulus: same load with `in_valid` low for 3 cycles between every byte.
  - Response: identical writes; no byte is duplicated or dropped; `in_ready`=0 in every WRITE cycle.
- **Length errors:**
  - `len`=0 → `err`=1 the next cycle, with no `im_WE`.
  - `len`=257 (DEPTH 256) → `err`=1.
  - A subsequent `start` with `len`=1 → leaves ERR, `err`=0.
- **Reset mid-load:**
  - Stimulus: `len`=4, assert `RST` after 6 bytes.
  - Response: reset values on the next cycle, `cpu_rst`=1, no further `im_WE`, no `done`.
- **Reload from RUN:**
  - Stimulus: in RUN, `start` with `len`=1, bytes AA BB CC DD.
  - Response: `cpu_rst`=1 the next cycle, one write at addr 0 with data 0xDDCCBBAA, `done` pulse, then RUN again.
- **Ignored start:**
  - Stimulus: pulse `start` with `len`=0 during RECV.
  - Response: no ERR, session continues, and the latched `len` is unchanged.
